pipeline_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage F/D/E/M/W integer pipeline. It sits beside the decode-stage forwarding path and covers the hazards forwarding cannot: load-use, outstanding data-memory loads, multi-cycle mul/div occupancy and exception redirect. It emits per-stage stall/flush enables to the pipeline registers and sequences the mul/div unit with a cycle counter.

---
 rtl/pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage F/D/E/M/W integer pipeline.
// Handles the hazards that the decode-stage forwarding path cannot resolve:
// load-use, outstanding data-memory accesses, multi-cycle mul/div occupancy
// of the E stage, and exception/eret redirect. It also sequences the mul/div
// unit with a down-counter.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   When defined, three 32-bit wrapping performance counters are added that
//   count the cycles in which load-use, memory wait or mul/div is the cause
//   of the winning stall.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   d_src1/d_src2       decode source register addresses
//   d_use1/d_use2       decode instruction actually reads src1/src2
//   e_valid, e_is_load  E holds a valid instruction / that instruction is a load
//   e_dst               E destination register
//   e_muldiv, e_is_div  E starts a mul/div this cycle, divide when e_is_div=1
//   m_mem_busy          M data-memory access not yet complete
//   f_mem_busy          instruction fetch not yet complete
//   exc_valid           exception/eret committed in M this cycle
//   stall_f..stall_m    hold the corresponding stage register
//   flush_d..flush_m    load a bubble into the stage register on the next edge
//   redirect            one-cycle pulse, fetch takes the exception vector
//   muldiv_busy         mul/div counter active
//   perf_*              (HAZARD_PERF_CNT_EN only) stall-cause cycle counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_src1,
  input  logic [4:0]  d_src2,
  input  logic        d_use1,
  input  logic        d_use2,
  input  logic        e_valid,
  input  logic        e_is_load,
  input  logic [4:0]  e_dst,
  input  logic        e_muldiv,
  input  logic        e_is_div,
  input  logic        m_mem_busy,
  input  logic        f_mem_busy,
  input  logic        exc_valid,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        redirect,
  output logic        muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mem_stalls,
  output logic [31:0] perf_muldiv_stalls
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MULDIV   = 2'd1;
  localparam logic [1:0] ST_EXC_WAIT = 2'd2;

  // The issue cycle counts toward occupancy, so the counter holds the
  // number of additional busy cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             load_use;
  logic [CNT_W-1:0] muldiv_load;

  // Register $0 is hardwired to zero, so a load targeting it never hazards.
  always_comb begin
    load_use = e_valid & e_is_load & (e_dst != 5'd0) &
               ((d_use1 & (d_src1 == e_dst)) | (d_use2 & (d_src2 == e_dst)));
    muldiv_load = e_is_div ? DIV_LOAD : MUL_LOAD;
  end

  // Next state, counter and per-stage controls. The if/else chain encodes
  // the cause priority: exception flush, memory wait, mul/div, load-use,
  // fetch wait. init_done_q keeps everything quiet for the first cycle
  // after reset release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b1;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    redirect    = 1'b0;

    if (!init_done_q) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_EXC_WAIT: begin
          if (m_mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
          end else begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            flush_m  = 1'b1;
            redirect = 1'b1;
            state_d  = ST_IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          if (exc_valid) begin
            // An exception abandons any mul/div in flight.
            cnt_d = '0;
            if (m_mem_busy) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              stall_e = 1'b1;
              stall_m = 1'b1;
              state_d = ST_EXC_WAIT;
            end else begin
              flush_d  = 1'b1;
              flush_e  = 1'b1;
              flush_m  = 1'b1;
              redirect = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            // The mul/div unit keeps counting even while memory stalls the
            // pipe, so its occupancy is a fixed number of cycles.
            if (state_q == ST_MULDIV) begin
              if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end else if (e_muldiv && !m_mem_busy && (muldiv_load != '0)) begin
              state_d = ST_MULDIV;
              cnt_d   = muldiv_load;
            end

            if (m_mem_busy) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              stall_e = 1'b1;
              stall_m = 1'b1;
            end else if (state_q == ST_MULDIV) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              stall_e = 1'b1;
              flush_m = 1'b1;
            end else if (load_use) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
            end else if (f_mem_busy) begin
              stall_f = 1'b1;
              flush_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign muldiv_busy = (state_q == ST_MULDIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // The winning cause is recovered from the output pattern: only a memory
  // wait raises stall_m, only mul/div raises stall_e without stall_m, and
  // only load-use raises flush_e together with stall_d.
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_md_q, perf_md_d;

  always_comb begin
    perf_lu_d  = perf_lu_q  + {31'd0, (flush_e & stall_d)};
    perf_mem_d = perf_mem_q + {31'd0, stall_m};
    perf_md_d  = perf_md_q  + {31'd0, (stall_e & ~stall_m)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_q  <= '0;
      perf_mem_q <= '0;
      perf_md_q  <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_mem_q <= perf_mem_d;
      perf_md_q  <= perf_md_d;
    end
  end

  assign perf_lu_stalls     = perf_lu_q;
  assign perf_mem_stalls    = perf_mem_q;
  assign perf_muldiv_stalls = perf_md_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. A cause-priority reference
// model (remaining busy cycles, pending exception, started flag) predicts
// the full output vector each cycle; directed scenarios add fixed expected
// values on top of the model.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MUL_CYCLES = 3;
  localparam int DIV_CYCLES = 33;

  // Output vector bit order:
  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, redirect, muldiv_busy}
  localparam logic [8:0] V_STALL_ALL = 9'b1111_0000_0;
  localparam logic [8:0] V_FLUSH_EXC = 9'b0000_1111_0;
  localparam logic [8:0] V_MULDIV    = 9'b1110_0010_0;
  localparam logic [8:0] V_LOAD_USE  = 9'b1100_0100_0;
  localparam logic [8:0] V_FETCH     = 9'b1000_1000_0;

  logic       clk;
  logic       reset;
  logic [4:0] d_src1, d_src2, e_dst;
  logic       d_use1, d_use2, e_valid, e_is_load;
  logic       e_muldiv, e_is_div, m_mem_busy, f_mem_busy, exc_valid;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, redirect, muldiv_busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit ref_started;
  int ref_busy_left;
  bit ref_exc_pending;

  pipeline_hazard_ctrl #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d_src1(d_src1),
    .d_src2(d_src2),
    .d_use1(d_use1),
    .d_use2(d_use2),
    .e_valid(e_valid),
    .e_is_load(e_is_load),
    .e_dst(e_dst),
    .e_muldiv(e_muldiv),
    .e_is_div(e_is_div),
    .m_mem_busy(m_mem_busy),
    .f_mem_busy(f_mem_busy),
    .exc_valid(exc_valid),
    .stall_f(stall_f),
    .stall_d(stall_d),
    .stall_e(stall_e),
    .stall_m(stall_m),
    .flush_d(flush_d),
    .flush_e(flush_e),
    .flush_m(flush_m),
    .redirect(redirect),
    .muldiv_busy(muldiv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] dut_vec();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, redirect, muldiv_busy};
  endfunction

  function automatic bit ref_load_use();
    return e_valid && e_is_load && (e_dst != 0) &&
           ((d_use1 && d_src1 == e_dst) || (d_use2 && d_src2 == e_dst));
  endfunction

  // Expected outputs for the current inputs, chosen by cause priority.
  function automatic logic [8:0] ref_expect();
    logic [8:0] busy_bit;
    if (reset || !ref_started) return 9'd0;
    busy_bit = (ref_busy_left > 0) ? 9'd1 : 9'd0;
    if (ref_exc_pending) return m_mem_busy ? V_STALL_ALL : V_FLUSH_EXC;
    if (exc_valid)       return (m_mem_busy ? V_STALL_ALL : V_FLUSH_EXC) | busy_bit;
    if (m_mem_busy)      return V_STALL_ALL | busy_bit;
    if (ref_busy_left > 0) return V_MULDIV | busy_bit;
    if (ref_load_use())  return V_LOAD_USE;
    if (f_mem_busy)      return V_FETCH;
    return 9'd0;
  endfunction

  function automatic void ref_reset();
    ref_started     = 1'b0;
    ref_busy_left   = 0;
    ref_exc_pending = 1'b0;
  endfunction

  // Model state advance at a rising edge, using the inputs of the ending cycle.
  function automatic void ref_update();
    if (reset) ref_reset();
    else if (!ref_started) ref_started = 1'b1;
    else if (ref_exc_pending) begin
      if (!m_mem_busy) ref_exc_pending = 1'b0;
    end else if (exc_valid) begin
      ref_busy_left   = 0;
      ref_exc_pending = m_mem_busy;
    end else if (ref_busy_left > 0) ref_busy_left--;
    else if (e_muldiv && !m_mem_busy) ref_busy_left = (e_is_div ? DIV_CYCLES : MUL_CYCLES) - 1;
  endfunction

  task automatic clear_inputs();
    d_src1 = 0; d_src2 = 0; e_dst = 0;
    d_use1 = 0; d_use2 = 0; e_valid = 0; e_is_load = 0;
    e_muldiv = 0; e_is_div = 0; m_mem_busy = 0; f_mem_busy = 0; exc_valid = 0;
  endtask

  // Move to just after the next rising edge, advancing the model with it.
  task automatic advance();
    @(posedge clk);
    ref_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ref_reset();
    clear_inputs();
    e_valid = 1; e_is_load = 1; e_dst = 7; d_src1 = 7; d_use1 = 1; f_mem_busy = 1;
    #2;
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: got %b want %b", dut_vec(), 9'd0);
    end
    advance();
    advance();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_first_cycle: got %b want %b", dut_vec(), 9'd0);
    end
    advance();
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_LOAD_USE || ref_expect() !== V_LOAD_USE) begin
      errors++;
      $display("[TB] FAIL reset_then_lu: got %b want %b", dut_vec(), V_LOAD_USE);
    end
    advance();
  endtask

  task automatic test_load_use();
    clear_inputs();
    e_valid = 1; e_is_load = 1; e_dst = 5; d_src1 = 5; d_use1 = 1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_LOAD_USE) begin
      errors++;
      $display("[TB] FAIL lu_src1: got %b want %b", dut_vec(), V_LOAD_USE);
    end
    advance();
    e_dst = 0; d_src1 = 0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("[TB] FAIL lu_reg0: got %b want %b", dut_vec(), 9'd0);
    end
    advance();
    e_dst = 9; d_src1 = 9; d_use1 = 0; d_src2 = 9; d_use2 = 1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_LOAD_USE) begin
      errors++;
      $display("[TB] FAIL lu_src2: got %b want %b", dut_vec(), V_LOAD_USE);
    end
    advance();
    d_use2 = 0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("[TB] FAIL lu_unused: got %b want %b", dut_vec(), 9'd0);
    end
    advance();
    e_is_load = 0; d_use2 = 1; f_mem_busy = 1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_FETCH) begin
      errors++;
      $display("[TB] FAIL fetch_wait: got %b want %b", dut_vec(), V_FETCH);
    end
    advance();
  endtask

  task automatic test_multiply();
    int busy_cycles = 0;
    int stall_e_cycles = 0;
    clear_inputs();
    e_muldiv = 1; e_is_div = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec() !== ref_expect()) begin
        errors++;
        $display("[TB] FAIL mul_cycle%0d: got %b want %b", cyc, dut_vec(), ref_expect());
      end
      if (muldiv_busy === 1'b1) busy_cycles++;
      if (stall_e === 1'b1) stall_e_cycles++;
      advance();
      e_muldiv = 0;
      f_mem_busy = (cyc == 1);
    end
    checks++;
    if (busy_cycles != MUL_CYCLES - 1 || stall_e_cycles != MUL_CYCLES - 1) begin
      errors++;
      $display("[TB] FAIL mul_occupancy: got busy %0d stall_e %0d want %0d", busy_cycles, stall_e_cycles, MUL_CYCLES - 1);
    end
  endtask

  task automatic test_divide_exception();
    clear_inputs();
    e_muldiv = 1; e_is_div = 1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      exc_valid = (cyc == 10);
      @(negedge clk);
      checks++;
      if (dut_vec() !== ref_expect()) begin
        errors++;
        $display("[TB] FAIL div_cycle%0d: got %b want %b", cyc, dut_vec(), ref_expect());
      end
      if (cyc == 10) begin
        checks++;
        if (dut_vec() !== (V_FLUSH_EXC | 9'd1)) begin
          errors++;
          $display("[TB] FAIL div_exc_flush: got %b want %b", dut_vec(), V_FLUSH_EXC | 9'd1);
        end
      end
      if (cyc == 11) begin
        checks++;
        if (muldiv_busy !== 1'b0 || redirect !== 1'b0) begin
          errors++;
          $display("[TB] FAIL div_exc_after: got busy %b redirect %b want 0 0", muldiv_busy, redirect);
        end
      end
      advance();
      e_muldiv = 0;
    end
  endtask

  task automatic test_exc_mem_wait();
    int redirects = 0;
    clear_inputs();
    for (int cyc = 0; cyc < 7; cyc++) begin
      m_mem_busy = (cyc < 4);
      exc_valid  = (cyc == 0 || cyc == 2);
      @(negedge clk);
      checks++;
      if (dut_vec() !== ref_expect()) begin
        errors++;
        $display("[TB] FAIL excw_cycle%0d: got %b want %b", cyc, dut_vec(), ref_expect());
      end
      if (cyc < 4 && dut_vec() !== V_STALL_ALL) begin
        errors++;
        $display("[TB] FAIL excw_hold%0d: got %b want %b", cyc, dut_vec(), V_STALL_ALL);
      end
      if (cyc == 4 && dut_vec() !== V_FLUSH_EXC) begin
        errors++;
        $display("[TB] FAIL excw_release: got %b want %b", dut_vec(), V_FLUSH_EXC);
      end
      if (cyc <= 4) checks++;
      if (redirect === 1'b1) redirects++;
      advance();
    end
    checks++;
    if (redirects != 1) begin
      errors++;
      $display("[TB] FAIL excw_pulses: got %0d want 1", redirects);
    end
  endtask

  task automatic test_mem_overlap_lu();
    clear_inputs();
    e_valid = 1; e_is_load = 1; e_dst = 12; d_src1 = 12; d_use1 = 1;
    m_mem_busy = 1; f_mem_busy = 1;
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_STALL_ALL) begin
      errors++;
      $display("[TB] FAIL mem_over_lu: got %b want %b", dut_vec(), V_STALL_ALL);
    end
    advance();
    m_mem_busy = 0;
    @(negedge clk);
    checks++;
    if (dut_vec() !== V_LOAD_USE) begin
      errors++;
      $display("[TB] FAIL lu_after_mem: got %b want %b", dut_vec(), V_LOAD_USE);
    end
    advance();
  endtask

  task automatic test_async_reset_mid_divide();
    clear_inputs();
    e_muldiv = 1; e_is_div = 1;
    advance();
    e_muldiv = 0;
    for (int cyc = 0; cyc < 4; cyc++) advance();
    @(negedge clk);
    checks++;
    if (dut_vec() !== (V_MULDIV | 9'd1)) begin
      errors++;
      $display("[TB] FAIL rst_div_busy: got %b want %b", dut_vec(), V_MULDIV | 9'd1);
    end
    advance();
    #2;
    reset = 1'b1;
    ref_reset();
    m_mem_busy = 1; f_mem_busy = 1;
    #1;
    checks++;
    if (dut_vec() !== 9'd0) begin
      errors++;
      $display("[TB] FAIL rst_immediate: got %b want %b", dut_vec(), 9'd0);
    end
    advance();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    advance();
    @(negedge clk);
    checks++;
    if (muldiv_busy !== 1'b0 || dut_vec() !== ref_expect()) begin
      errors++;
      $display("[TB] FAIL rst_div_release: got %b want %b", dut_vec(), ref_expect());
    end
    advance();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      d_src1     = 5'($urandom_range(0, 3));
      d_src2     = 5'($urandom_range(0, 3));
      e_dst      = 5'($urandom_range(0, 3));
      d_use1     = 1'($urandom_range(0, 1));
      d_use2     = 1'($urandom_range(0, 1));
      e_valid    = ($urandom_range(0, 3) != 0);
      e_is_load  = 1'($urandom_range(0, 1));
      e_muldiv   = ($urandom_range(0, 7) == 0);
      e_is_div   = ($urandom_range(0, 3) == 0);
      m_mem_busy = ($urandom_range(0, 4) == 0);
      f_mem_busy = ($urandom_range(0, 3) == 0);
      exc_valid  = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== ref_expect()) begin
        errors++;
        $display("[TB] FAIL rand_cycle%0d: got %b want %b", cyc, dut_vec(), ref_expect());
      end
      advance();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    ref_reset();
    test_reset();
    test_load_use();
    test_multiply();
    test_divide_exception();
    test_exc_mem_wait();
    test_mem_overlap_lu();
    test_async_reset_mid_divide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
